// File: rtl/ahb_write_buffer.sv
// Posted-write buffer between an AHB-Lite master and the downstream interconnect.
// Bufferable writes are queued and drained in order; everything else passes through.
module ahb_write_buffer #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    src_hready_resp,
    input  logic                    src_hready,
    output logic                    src_hresp,
    input  logic [W_ADDR-1:0]       src_haddr,
    input  logic                    src_hwrite,
    input  logic [1:0]              src_htrans,
    input  logic [2:0]              src_hsize,
    input  logic [2:0]              src_hburst,
    input  logic [3:0]              src_hprot,
    input  logic                    src_hmastlock,
    input  logic [W_DATA-1:0]       src_hwdata,
    output logic [W_DATA-1:0]       src_hrdata,
    input  logic                    dst_hready_resp,
    output logic                    dst_hready,
    input  logic                    dst_hresp,
    output logic [W_ADDR-1:0]       dst_haddr,
    output logic                    dst_hwrite,
    output logic [1:0]              dst_htrans,
    output logic [2:0]              dst_hsize,
    output logic [2:0]              dst_hburst,
    output logic [3:0]              dst_hprot,
    output logic                    dst_hmastlock,
    output logic [W_DATA-1:0]       dst_hwdata,
    input  logic [W_DATA-1:0]       dst_hrdata,
    output logic [$clog2(DEPTH):0]  wbuf_level,
    output logic                    wbuf_err,
    output logic [W_ADDR-1:0]       wbuf_err_addr,
    input  logic                    err_clr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

    typedef enum logic [3:0] {
        SIdle, SWdph, SRwait, SUwait, SRdph, SUdph, SRdone, SUdone, SErr0, SErr1
    } src_state_e;

    typedef enum logic {DIdle, DDph} drn_state_e;

    src_state_e src_q, src_d;
    drn_state_e drn_q, drn_d;

    logic [W_ADDR-1:0] addr_q;
    logic [2:0]        size_q;
    logic [3:0]        prot_q;
    logic [W_DATA-1:0] rdata_q, rdata_d;
    logic [LW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              err_q, err_d;
    logic [W_ADDR-1:0] err_addr_q, err_addr_d;

    logic [W_ADDR-1:0] fifo_addr [DEPTH];
    logic [2:0]        fifo_size [DEPTH];
    logic [3:0]        fifo_prot [DEPTH];
    logic [W_DATA-1:0] fifo_data [DEPTH];

    logic [LW-1:0] level;
    logic          empty, full;
    logic          addr_accept, push, pop, pass_issue, drain_issue, err_set;
    logic [AW-1:0] head, tail;

    logic unused_ok;
    assign unused_ok = ^{src_hburst, src_hmastlock, src_htrans[0]};

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == FullLevel);
    assign head  = rd_ptr_q[AW-1:0];
    assign tail  = wr_ptr_q[AW-1:0];

    // Upstream response is a pure function of state and the registered fill level
    always_comb begin
        src_hready_resp = 1'b0;
        src_hresp       = 1'b0;
        case (src_q)
            SIdle, SRdone, SUdone: src_hready_resp = 1'b1;
            SWdph:                 src_hready_resp = !full;
            SErr0:                 src_hresp = 1'b1;
            SErr1: begin
                src_hready_resp = 1'b1;
                src_hresp       = 1'b1;
            end
            default: ;
        endcase
    end

    assign addr_accept = src_hready && src_htrans[1] && src_hready_resp;
    assign push        = (src_q == SWdph) && !full;
    // Pass-through only starts once every posted write has fully retired
    assign pass_issue  = ((src_q == SRwait) || (src_q == SUwait)) && empty && (drn_q == DIdle);
    assign drain_issue = (drn_q == DIdle) && !empty;

    always_comb begin
        src_d   = src_q;
        rdata_d = rdata_q;
        if (src_hready_resp) begin
            if (addr_accept) begin
                src_d = !src_hwrite ? SRwait : (src_hprot[2] ? SWdph : SUwait);
            end else begin
                src_d = SIdle;
            end
        end else begin
            case (src_q)
                SRwait: if (pass_issue && dst_hready_resp) src_d = SRdph;
                SUwait: if (pass_issue && dst_hready_resp) src_d = SUdph;
                SRdph, SUdph: begin
                    if (dst_hready_resp) begin
                        if (dst_hresp) begin
                            src_d = SErr0;
                        end else if (src_q == SRdph) begin
                            src_d   = SRdone;
                            rdata_d = dst_hrdata;
                        end else begin
                            src_d = SUdone;
                        end
                    end
                end
                SErr0:   src_d = SErr1;
                default: ;
            endcase
        end
    end

    always_comb begin
        drn_d   = drn_q;
        pop     = 1'b0;
        err_set = 1'b0;
        case (drn_q)
            DIdle: if (drain_issue && dst_hready_resp) drn_d = DDph;
            DDph: begin
                if (dst_hready_resp) begin
                    pop     = 1'b1;
                    err_set = dst_hresp;
                    drn_d   = DIdle;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + LW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + LW'(1) : rd_ptr_q;
        err_d      = err_set | (err_q & ~err_clr);
        err_addr_d = (err_set && !err_q) ? fifo_addr[head] : err_addr_q;
    end

    always_comb begin
        dst_htrans = 2'b00;
        dst_haddr  = '0;
        dst_hwrite = 1'b0;
        dst_hsize  = 3'b000;
        dst_hprot  = 4'b0000;
        dst_hwdata = '0;
        if (drain_issue) begin
            dst_htrans = 2'b10;
            dst_haddr  = fifo_addr[head];
            dst_hwrite = 1'b1;
            dst_hsize  = fifo_size[head];
            dst_hprot  = fifo_prot[head];
        end else if (pass_issue) begin
            dst_htrans = 2'b10;
            dst_haddr  = addr_q;
            dst_hwrite = (src_q == SUwait);
            dst_hsize  = size_q;
            dst_hprot  = prot_q;
        end
        if (drn_q == DDph) begin
            dst_hwdata = fifo_data[head];
        end else if (src_q == SUdph) begin
            dst_hwdata = src_hwdata;
        end
    end

    assign dst_hready    = dst_hready_resp;
    assign dst_hburst    = 3'b000;
    assign dst_hmastlock = 1'b0;
    assign src_hrdata    = rdata_q;
    assign wbuf_level    = level;
    assign wbuf_err      = err_q;
    assign wbuf_err_addr = err_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q      <= SIdle;
            drn_q      <= DIdle;
            addr_q     <= '0;
            size_q     <= 3'b000;
            prot_q     <= 4'b0000;
            rdata_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            src_q      <= src_d;
            drn_q      <= drn_d;
            rdata_q    <= rdata_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            if (addr_accept) begin
                addr_q <= src_haddr;
                size_q <= src_hsize;
                prot_q <= src_hprot;
            end
        end
    end

    // Payload storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= addr_q;
            fifo_size[tail] <= size_q;
            fifo_prot[tail] <= prot_q;
            fifo_data[tail] <= src_hwdata;
        end
    end

endmodule

// File: tb/tb_ahb_write_buffer.sv
// Scoreboard bench: stimulus pushes expected upstream responses and downstream transfers,
// independent monitors on each bus pop and compare.
module tb_ahb_write_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_hready_resp, src_hready, src_hresp, src_hwrite, src_hmastlock;
    logic [31:0] src_haddr, src_hwdata, src_hrdata;
    logic [1:0]  src_htrans;
    logic [2:0]  src_hsize, src_hburst;
    logic [3:0]  src_hprot;
    logic        dst_hready_resp, dst_hready, dst_hresp, dst_hwrite, dst_hmastlock;
    logic [31:0] dst_haddr, dst_hwdata, dst_hrdata;
    logic [1:0]  dst_htrans;
    logic [2:0]  dst_hsize, dst_hburst;
    logic [3:0]  dst_hprot;
    logic [2:0]  wbuf_level;
    logic        wbuf_err, err_clr;
    logic [31:0] wbuf_err_addr;

    always #5 clk = ~clk;
    assign src_hready = src_hready_resp;

    ahb_write_buffer #(.W_ADDR(32), .W_DATA(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .src_hready_resp(src_hready_resp), .src_hready(src_hready), .src_hresp(src_hresp),
        .src_haddr(src_haddr), .src_hwrite(src_hwrite), .src_htrans(src_htrans),
        .src_hsize(src_hsize), .src_hburst(src_hburst), .src_hprot(src_hprot),
        .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata), .src_hrdata(src_hrdata),
        .dst_hready_resp(dst_hready_resp), .dst_hready(dst_hready), .dst_hresp(dst_hresp),
        .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite), .dst_htrans(dst_htrans),
        .dst_hsize(dst_hsize), .dst_hburst(dst_hburst), .dst_hprot(dst_hprot),
        .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata), .dst_hrdata(dst_hrdata),
        .wbuf_level(wbuf_level), .wbuf_err(wbuf_err), .wbuf_err_addr(wbuf_err_addr),
        .err_clr(err_clr)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  prot;
    } cmd_t;

    // wmode: 0 = no wait states allowed, 1 = must stall, 2 = don't care
    typedef struct {
        logic        err;
        logic        is_read;
        logic [31:0] rdata;
        int          wmode;
    } src_exp_t;

    cmd_t     cmd_q[$];
    cmd_t     dst_exp_q[$];
    src_exp_t src_exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int peak    = 0;
    int stall_until = 0;
    int sl_cyc = 0;
    bit dph_stall = 1'b0;
    logic [31:0] rd_val = 32'h0;
    bit m_aph, m_dph;
    cmd_t m_acmd, m_dcmd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue(input logic write, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] prot, input logic err, input logic [31:0] rdata,
                         input int wmode);
        cmd_t c;
        src_exp_t s;
        c.write = write; c.addr = addr; c.data = data; c.prot = prot;
        s.err = err; s.is_read = !write; s.rdata = rdata; s.wmode = wmode;
        cmd_q.push_back(c);
        dst_exp_q.push_back(c);
        src_exp_q.push_back(s);
    endtask

    function automatic bit busy();
        return (cmd_q.size() != 0) || m_aph || m_dph || (src_exp_q.size() != 0) ||
               (dst_exp_q.size() != 0);
    endfunction

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (busy() && cyc < 300) begin
            @(negedge clk); #1;
            cyc++;
            if (int'(wbuf_level) > peak) peak = int'(wbuf_level);
        end
        chk(name, 32'(busy()), 32'd0);
    endtask

    function automatic bit is_err(input logic [31:0] a);
        return (a == 32'h300) || (a == 32'h304) || (a == 32'h308) || (a == 32'h310);
    endfunction

    // Upstream AHB master: pipelined, one command per address phase
    initial begin : master
        src_htrans = 2'b00; src_haddr = '0; src_hwrite = 1'b0; src_hsize = 3'b010;
        src_hburst = 3'b000; src_hprot = 4'h0; src_hmastlock = 1'b0; src_hwdata = '0;
        m_aph = 1'b0; m_dph = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_aph = 1'b0;
                m_dph = 1'b0;
            end else if (src_hready_resp) begin
                m_dph  = m_aph;
                m_dcmd = m_acmd;
                m_aph  = (cmd_q.size() != 0);
                if (m_aph) m_acmd = cmd_q.pop_front();
            end
            @(posedge clk); #1;
            src_htrans = m_aph ? 2'b10 : 2'b00;
            src_haddr  = m_acmd.addr;
            src_hwrite = m_acmd.write;
            src_hprot  = m_acmd.prot;
            src_hwdata = (m_dph && m_dcmd.write) ? m_dcmd.data : 32'h0;
        end
    end

    // Downstream slave: optional global stall window, optional data-phase-only stall
    initial begin : slave
        bit          sl_dph;
        logic [31:0] sl_addr;
        logic        sl_write;
        bit          rdy;
        dst_hready_resp = 1'b1; dst_hresp = 1'b0; dst_hrdata = '0;
        sl_dph = 1'b0; sl_addr = '0; sl_write = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sl_dph = 1'b0;
            end else if (dst_hready_resp) begin
                sl_dph   = dst_htrans[1];
                sl_addr  = dst_haddr;
                sl_write = dst_hwrite;
            end
            @(posedge clk); #1;
            sl_cyc++;
            rdy = (sl_cyc > stall_until) && !(dph_stall && sl_dph);
            dst_hready_resp = rdy;
            dst_hresp  = rdy && sl_dph && is_err(sl_addr);
            dst_hrdata = (sl_dph && !sl_write) ? rd_val : 32'h0;
        end
    end

    initial begin : mon_src
        bit s_dph, s_err1;
        int s_waits;
        src_exp_t e;
        s_dph = 1'b0; s_err1 = 1'b0; s_waits = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                s_dph = 1'b0; s_err1 = 1'b0; s_waits = 0;
            end else if (!src_hready_resp) begin
                if (s_dph) begin
                    s_waits++;
                    if (src_hresp) s_err1 = 1'b1;
                end
            end else begin
                if (s_dph) begin
                    chk("src_pending", 32'(src_exp_q.size() != 0), 32'd1);
                    if (src_exp_q.size() != 0) begin
                        e = src_exp_q.pop_front();
                        chk("src_resp", {30'b0, s_err1, src_hresp}, e.err ? 32'd3 : 32'd0);
                        if (e.is_read) chk("src_hrdata", src_hrdata, e.rdata);
                        if (e.wmode == 0) chk("src_waits", 32'(s_waits), 32'd0);
                        else if (e.wmode == 1) chk("src_stalled", 32'(s_waits > 0), 32'd1);
                    end
                end
                s_dph = src_htrans[1]; s_err1 = 1'b0; s_waits = 0;
            end
        end
    end

    initial begin : mon_dst
        bit          d_dph;
        logic [31:0] d_addr;
        logic        d_write;
        logic [3:0]  d_prot;
        cmd_t c;
        d_dph = 1'b0; d_addr = '0; d_write = 1'b0; d_prot = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                d_dph = 1'b0;
            end else if (dst_hready_resp) begin
                if (d_dph) begin
                    chk("dst_pending", 32'(dst_exp_q.size() != 0), 32'd1);
                    if (dst_exp_q.size() != 0) begin
                        c = dst_exp_q.pop_front();
                        chk("dst_haddr", d_addr, c.addr);
                        chk("dst_hwrite", 32'(d_write), 32'(c.write));
                        chk("dst_hprot", 32'(d_prot), 32'(c.prot));
                        if (c.write) chk("dst_hwdata", dst_hwdata, c.data);
                    end
                end
                d_dph = dst_htrans[1]; d_addr = dst_haddr;
                d_write = dst_hwrite; d_prot = dst_hprot;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, got busy bench, expected completion");
        $fatal(1);
    end

    initial begin : main
        int cyc;
        rst = 1'b1; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_src_hready_resp", 32'(src_hready_resp), 32'd1);
        chk("rst_src_hresp", 32'(src_hresp), 32'd0);
        chk("rst_src_hrdata", src_hrdata, 32'h0);
        chk("rst_dst_htrans", 32'(dst_htrans), 32'd0);
        chk("rst_wbuf_level", 32'(wbuf_level), 32'd0);
        chk("rst_wbuf_err", 32'(wbuf_err), 32'd0);
        chk("rst_wbuf_err_addr", wbuf_err_addr, 32'h0);

        // Back-to-back posted writes, zero-wait downstream
        peak = 0;
        for (int i = 0; i < 4; i++) issue(1'b1, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i),
                                          4'b1111, 1'b0, 32'h0, 0);
        wait_idle("t1_idle");
        chk("t1_peak_level_ge3", 32'(peak >= 3), 32'd1);

        // Fifth write must stall on a full buffer while downstream is held off
        stall_until = sl_cyc + 10;
        for (int i = 0; i < 5; i++) issue(1'b1, 32'h140 + 32'(4 * i), 32'hB000_0000 + 32'(i),
                                          4'b0100, 1'b0, 32'h0, (i == 4) ? 1 : 0);
        wait_idle("t2_idle");

        // Read waits behind two posted writes
        rd_val = 32'hDEAD_BEEF;
        issue(1'b1, 32'h180, 32'hC000_0180, 4'b1111, 1'b0, 32'h0, 0);
        issue(1'b1, 32'h184, 32'hC000_0184, 4'b1111, 1'b0, 32'h0, 0);
        issue(1'b0, 32'h200, 32'h0, 4'b1111, 1'b0, 32'hDEAD_BEEF, 2);
        wait_idle("t3_idle");

        // Posted-write errors: sticky flag, first address kept, clear
        issue(1'b1, 32'h300, 32'hD000_0300, 4'b0100, 1'b0, 32'h0, 0);
        wait_idle("t4a_idle");
        repeat (2) @(negedge clk);
        chk("t4_err_set", 32'(wbuf_err), 32'd1);
        chk("t4_err_addr", wbuf_err_addr, 32'h300);
        issue(1'b1, 32'h304, 32'hD000_0304, 4'b0100, 1'b0, 32'h0, 0);
        wait_idle("t4b_idle");
        repeat (2) @(negedge clk);
        chk("t4_err_still_set", 32'(wbuf_err), 32'd1);
        chk("t4_err_addr_kept", wbuf_err_addr, 32'h300);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("t4_err_cleared", 32'(wbuf_err), 32'd0);

        // Non-bufferable writes: OKAY then two-cycle ERROR upstream
        issue(1'b1, 32'h400, 32'hE000_0400, 4'b0011, 1'b0, 32'h0, 2);
        issue(1'b1, 32'h308, 32'hE000_0308, 4'b0011, 1'b1, 32'h0, 2);
        wait_idle("t5_idle");
        repeat (2) @(negedge clk);
        chk("t5_no_posted_err", 32'(wbuf_err), 32'd0);

        // Set and clear in the same cycle: set wins, address reloads
        err_clr = 1'b1;
        issue(1'b1, 32'h310, 32'hF000_0310, 4'b0100, 1'b0, 32'h0, 2);
        wait_idle("t5b_idle");
        @(posedge clk); #1 err_clr = 1'b0;
        @(negedge clk);
        chk("t5b_set_wins", 32'(wbuf_err), 32'd1);
        chk("t5b_err_addr", wbuf_err_addr, 32'h310);

        // Reset while the drain sits in its data phase with three entries queued
        dph_stall = 1'b1;
        for (int i = 0; i < 3; i++) issue(1'b1, 32'h600 + 32'(4 * i), 32'h6000_0000 + 32'(i),
                                          4'b0100, 1'b0, 32'h0, 0);
        cyc = 0;
        while (!(wbuf_level == 3'd3 && src_exp_q.size() == 0 && !m_aph && !m_dph) &&
               cyc < 100) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("t6_level_before_rst", 32'(wbuf_level), 32'd3);
        chk("t6_dph_hwdata", dst_hwdata, 32'h6000_0000);
        chk("t6_dph_htrans", 32'(dst_htrans), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        dph_stall = 1'b0;
        dst_exp_q.delete();
        @(negedge clk);
        chk("t6_level_after_rst", 32'(wbuf_level), 32'd0);
        chk("t6_htrans_after_rst", 32'(dst_htrans), 32'd0);
        chk("t6_hready_after_rst", 32'(src_hready_resp), 32'd1);
        chk("t6_err_after_rst", 32'(wbuf_err), 32'd0);
        chk("t6_err_addr_after_rst", wbuf_err_addr, 32'h0);

        // Normal operation resumes after reset
        rd_val = 32'h1234_5678;
        issue(1'b1, 32'h700, 32'h0000_0077, 4'b1111, 1'b0, 32'h0, 0);
        issue(1'b0, 32'h704, 32'h0, 4'b0010, 1'b0, 32'h1234_5678, 2);
        wait_idle("t7_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_write_buffer.md
Name: ahb_write_buffer

Overview:
- Posted-write buffer between the write-back cache's downstream AHB-Lite master and the memory/interconnect.
- Bufferable writes are absorbed into a DEPTH-entry FIFO with zero wait states and drained downstream in order.
- Reads and non-bufferable writes wait until the FIFO is empty, then pass through as single transfers with their error response.
- Errors on posted writes cannot be returned upstream; they raise a sticky flag and capture the failing address.

Parameters:
W_ADDR, 32, address width
W_DATA, 32, data width (bytes power of 2)
DEPTH, 4, FIFO entries; power of 2, >=2

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
src_hready_resp  out  1  upstream HREADYOUT
src_hready  in  1  upstream HREADY
src_hresp  out  1  upstream HRESP
src_haddr  in  W_ADDR  upstream HADDR
src_hwrite  in  1  upstream HWRITE
src_htrans  in  2  upstream HTRANS
src_hsize  in  3  upstream HSIZE
src_hburst  in  3  ignored
src_hprot  in  4  upstream HPROT; bit2 = bufferable
src_hmastlock  in  1  ignored
src_hwdata  in  W_DATA  upstream HWDATA
src_hrdata  out  W_DATA  upstream HRDATA
dst_hready_resp  in  1  downstream HREADYOUT
dst_hready  out  1  = dst_hready_resp
dst_hresp  in  1  downstream HRESP
dst_haddr  out  W_ADDR  downstream HADDR
dst_hwrite  out  1  downstream HWRITE
dst_htrans  out  2  IDLE (00) or NONSEQ (10) only
dst_hsize  out  3  downstream HSIZE
dst_hburst  out  3  tied 000
dst_hprot  out  4  hprot of the transfer being issued
dst_hmastlock  out  1  tied 0
dst_hwdata  out  W_DATA  downstream HWDATA
dst_hrdata  in  W_DATA  downstream HRDATA
wbuf_level  out  $clog2(DEPTH)+1  FIFO occupancy
wbuf_err  out  1  sticky posted-write error
wbuf_err_addr  out  W_ADDR  address of first posted-write error
err_clr  in  1  clears wbuf_err

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous, active-high.
- Reset values:
  - src FSM in S_IDLE, drain FSM in D_IDLE, FIFO empty.
  - src_hready_resp=1, src_hresp=0, src_hrdata=0.
  - dst_htrans=00, wbuf_level=0, wbuf_err=0, wbuf_err_addr=0.
  - Reset mid-transfer discards FIFO contents and any in-flight state.
- Upstream address phase: src_hready && src_htrans[1].
  - Captures haddr, hsize, hprot.
  - Next state: S_WDPH if write with hprot[2]=1; S_UWAIT if write with hprot[2]=0; S_RWAIT if read.
  - Sampled in any state where src_hready_resp=1 (S_IDLE, S_WDPH accepting, S_RDONE, S_UDONE, S_ERR1); otherwise next state is S_IDLE.
- S_WDPH (posted write):
  - src_hready_resp = !full.
  - When !full: push {addr, size, hprot, src_hwdata}, respond OKAY, leave the state.
  - Full: stall. A pop in the same cycle does not unstall until the following cycle.
- S_RWAIT / S_UWAIT:
  - src_hready_resp=0.
  - Wait until FIFO empty and drain FSM in D_IDLE.
  - Then drive a dst address phase in that cycle: NONSEQ, captured addr/size/hprot, hwrite = 0 for read, 1 for write.
  - Advance to S_RDPH / S_UDPH when dst_hready.
- S_UDPH: dst_hwdata = src_hwdata (held stable by the AHB stall).
- S_RDPH / S_UDPH:
  - On dst_hready && !dst_hresp: go to S_RDONE (latch dst_hrdata) or S_UDONE.
  - On dst_hready && dst_hresp: go to S_ERR0.
- Completion and error states:
  - S_RDONE: hready_resp=1, src_hrdata = latched register.
  - S_UDONE: hready_resp=1.
  - S_ERR0: hresp=1, hready_resp=0.
  - S_ERR1: hresp=1, hready_resp=1.
- Drain FSM, D_IDLE:
  - If FIFO non-empty and src FSM not in S_RWAIT/S_UWAIT address issue, drive NONSEQ write with the head entry's addr/size/hprot.
  - Advance to D_DPH when dst_hready.
- Drain FSM, D_DPH:
  - dst_hwdata = head data, dst_htrans=00.
  - On dst_hready: pop and return to D_IDLE.
  - If dst_hresp is also set: set wbuf_err and, if wbuf_err was 0, load wbuf_err_addr.
- Drain throughput: one write per 2 cycles with zero-wait downstream.
- Drain/read ordering: drain and the read/unbuffered path never drive dst in the same cycle. Once the FIFO is empty the pass-through path owns the bus, and no new pushes can occur while it does.
- Error flag: err_clr clears wbuf_err. If set and clear coincide, set wins.
- Level: wbuf_level updates the cycle after a push/pop. Simultaneous push and pop leave it unchanged. Head and tail pointers wrap modulo DEPTH.
- Upstream hresp: src_hresp is never asserted for posted writes.

Test Plan:
- Four bufferable writes back-to-back to 0x100..0x10C (hprot=4'b1111), dst zero-wait -> each upstream data phase 0 wait; wbuf_level peaks ≥3; dst sees 4 NONSEQ writes in order with correct data.
- Five bufferable writes with DEPTH=4 and dst_hready_resp held low 10 cycles -> fifth write stalls (src_hready_resp=0) until first pop, then completes; no data lost.
- Two posted writes, then a read of 0x200 returning 0xDEADBEEF -> read is issued downstream only after both writes complete; src_hrdata=0xDEADBEEF in S_RDONE.
- Posted write to 0x300 erroring downstream -> upstream OKAY; wbuf_err=1, wbuf_err_addr=0x300; second error keeps 0x300; err_clr -> wbuf_err=0.
- Non-bufferable write (hprot=4'b0011) erroring -> upstream two-cycle ERROR response (hresp high with hready low, then both high).
- rst asserted while drain is in D_DPH with 3 entries queued -> next cycle wbuf_level=0, dst_htrans=00, src_hready_resp=1.
